// File: rtl/map_rom_arbiter.sv
// Shares one map ROM between the stallable wall tracer (req/ack) and the per-cycle overlay; 1-cycle latency for both.
// Overlay wins unless the tracer has waited TR_MAX_WAIT cycles; a dropped overlay lookup is flagged on o_ov_miss.
module map_rom_arbiter #(
    parameter int MAP_WBITS   = 5,
    parameter int MAP_HBITS   = 5,
    parameter int TR_MAX_WAIT = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_frame_start,
    input  logic                 i_tr_req,
    input  logic [MAP_WBITS-1:0] i_tr_col,
    input  logic [MAP_HBITS-1:0] i_tr_row,
    output logic                 o_tr_ack,
    output logic [1:0]           o_tr_val,
    input  logic                 i_ov_req,
    input  logic [MAP_WBITS-1:0] i_ov_col,
    input  logic [MAP_HBITS-1:0] i_ov_row,
    output logic                 o_ov_valid,
    output logic [1:0]           o_ov_val,
    output logic                 o_ov_miss,
    output logic [MAP_WBITS-1:0] o_map_col,
    output logic [MAP_HBITS-1:0] o_map_row,
    input  logic [1:0]           i_map_val
);

    localparam int AW = MAP_WBITS + MAP_HBITS;
    localparam logic [3:0] WAIT_MAX = 4'(TR_MAX_WAIT);

    logic [3:0]    wait_cnt;
    logic          cache_vld;
    logic [AW-1:0] cache_addr;
    logic [1:0]    cache_val;

    logic [AW-1:0] ov_addr;
    logic          ov_hit;
    logic          tr_gnt;
    logic          ov_gnt;
    logic          ov_drop;

    assign ov_addr = {i_ov_row, i_ov_col};

    always_comb begin
        ov_hit  = i_ov_req && cache_vld && (ov_addr == cache_addr);
        tr_gnt  = 1'b0;
        ov_gnt  = 1'b0;
        ov_drop = 1'b0;
        if (ov_hit) begin
            // Cache serves the overlay, so the ROM is free for the tracer.
            tr_gnt = i_tr_req;
        end else if (i_tr_req && (wait_cnt == WAIT_MAX)) begin
            tr_gnt  = 1'b1;
            ov_drop = i_ov_req;
        end else if (i_ov_req) begin
            ov_gnt = 1'b1;
        end else begin
            tr_gnt = i_tr_req;
        end
    end

    assign o_map_col = ov_gnt ? i_ov_col : i_tr_col;
    assign o_map_row = ov_gnt ? i_ov_row : i_tr_row;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_tr_ack   <= 1'b0;
            o_tr_val   <= 2'd0;
            o_ov_valid <= 1'b0;
            o_ov_val   <= 2'd0;
            o_ov_miss  <= 1'b0;
            wait_cnt   <= 4'd0;
            cache_vld  <= 1'b0;
            cache_addr <= '0;
            cache_val  <= 2'd0;
        end else begin
            o_tr_ack   <= tr_gnt;
            o_ov_valid <= ov_hit || ov_gnt;
            o_ov_miss  <= ov_drop;
            if (tr_gnt) begin
                o_tr_val <= i_map_val;
            end
            if (ov_hit) begin
                o_ov_val <= cache_val;
            end else if (ov_gnt) begin
                o_ov_val <= i_map_val;
            end

            if (ov_gnt) begin
                cache_addr <= ov_addr;
                cache_val  <= i_map_val;
            end
            // Frame start invalidates even a same-edge fill.
            if (i_frame_start) begin
                cache_vld <= 1'b0;
            end else if (ov_gnt) begin
                cache_vld <= 1'b1;
            end

            if (i_frame_start || tr_gnt) begin
                wait_cnt <= 4'd0;
            end else if (i_tr_req && (wait_cnt != WAIT_MAX)) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

endmodule
